// File: rtl/blit_arbiter_pkg.sv
// Shared types for the blitter command-port arbiter: FSM states, the packed
// blit command layout and blitter operation codes.
package blit_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    localparam logic [2:0] BLIT_OP_NOP    = 3'd0;
    localparam logic [2:0] BLIT_OP_COPY   = 3'd1;
    localparam logic [2:0] BLIT_OP_FILL   = 3'd2;
    localparam logic [2:0] BLIT_OP_SPRITE = 3'd3;
    localparam logic [2:0] BLIT_OP_SCROLL = 3'd4;

    // {op[31:29], src[28:17], srcHeight[16:13], destX[12:6], destY[5:0]}
    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] src;
        logic [3:0]  src_height;
        logic [6:0]  dest_x;
        logic [5:0]  dest_y;
    } blit_cmd_t;

    function automatic logic [31:0] blit_pack(input logic [2:0] op, input logic [11:0] src,
                                              input logic [3:0] h, input logic [6:0] x,
                                              input logic [5:0] y);
        return {op, src, h, x, y};
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blit_arbiter_if.sv
// Requester handshakes plus the blitter command/status bus, as seen by the arbiter.
interface blit_arbiter_if #(parameter int CNT_W = 16);

    logic             req0;
    logic [31:0]      cmd0;
    logic             gnt0;
    logic             done0;
    logic             req1;
    logic [31:0]      cmd1;
    logic             gnt1;
    logic             done1;
    logic [2:0]       blit_op;
    logic [11:0]      blit_src;
    logic [3:0]       blit_srcHeight;
    logic [6:0]       blit_destX;
    logic [5:0]       blit_destY;
    logic             blit_enable;
    logic             blit_ready;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] blit_count;

    modport slave (
        input  req0, cmd0, req1, cmd1, blit_ready,
        output gnt0, done0, gnt1, done1,
        output blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY, blit_enable,
        output busy, err, blit_count
    );

    modport master (
        output req0, cmd0, req1, cmd1, blit_ready,
        input  gnt0, done0, gnt1, done1,
        input  blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY, blit_enable,
        input  busy, err, blit_count
    );

endinterface

// File: rtl/blit_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie, picks the port that was not served last.
module blit_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic sel_o
);

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        valid_o = req0_i | req1_i;
        sel_o   = 1'b0;
        if (req0_i && req1_i) begin
            sel_o = ~last_i;
        end else if (req1_i) begin
            sel_o = 1'b1;
        end
    end

endmodule

// File: rtl/blit_arbiter.sv
// Shares the blitter command port between CPU (port 0) and debug (port 1):
// grants one command at a time, pulses blit_enable and tracks blit_ready to completion.
module blit_arbiter
    import blit_arbiter_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 8,
    parameter int DONE_TIMEOUT = 65535,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    blit_arbiter_if.slave bus
);

    localparam int unsigned TMR_MAX = max_u(BUSY_TIMEOUT, DONE_TIMEOUT);
    localparam int          TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] BUSY_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);

    state_e           state_q;
    blit_cmd_t        cmd_q;
    logic             enable_q;
    logic             owner_q;
    logic             last_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic pick_valid, pick_sel;
    logic grant, busy_fin, done_fin, complete;

    blit_rr_pick u_pick (
        .req0_i  (bus.req0),
        .req1_i  (bus.req1),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .sel_o   (pick_sel)
    );

    always_comb begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        count_d = count_q + 1'b1;
    end

    // gnt/done are decoded in the cycle the condition holds so done lands on
    // the same cycle blit_ready returns and the next grant can follow right after.
    assign grant    = (state_q == ST_IDLE) && bus.blit_ready && pick_valid && !rst;
    assign busy_fin = (state_q == ST_WAIT_BUSY) && bus.blit_ready && (timer_q == BUSY_LAST);
    assign done_fin = (state_q == ST_WAIT_DONE) && bus.blit_ready;
    assign complete = (busy_fin || done_fin) && !rst;

    assign bus.gnt0           = grant && !pick_sel;
    assign bus.gnt1           = grant && pick_sel;
    assign bus.done0          = complete && !owner_q;
    assign bus.done1          = complete && owner_q;
    assign bus.busy           = grant || (state_q != ST_IDLE);
    assign bus.blit_op        = cmd_q.op;
    assign bus.blit_src       = cmd_q.src;
    assign bus.blit_srcHeight = cmd_q.src_height;
    assign bus.blit_destX     = cmd_q.dest_x;
    assign bus.blit_destY     = cmd_q.dest_y;
    assign bus.blit_enable    = enable_q;
    assign bus.err            = err_q;
    assign bus.blit_count     = count_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            enable_q <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
            count_q  <= '0;
            timer_q  <= '0;
        end else begin
            enable_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        cmd_q    <= pick_sel ? bus.cmd1 : bus.cmd0;
                        owner_q  <= pick_sel;
                        enable_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!bus.blit_ready) begin
                        timer_q <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else if (busy_fin) begin
                        // blitter never went busy: a zero-length op counts as done
                        count_q <= count_d;
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_fin) begin
                        count_q <= count_d;
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end else if (timer_q == DONE_LAST) begin
                        err_q   <= 1'b1;
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blit_arbiter.sv
// Randomized scoreboard bench for blit_arbiter with a behavioural blitter and arbitration model.
module tb_blit_arbiter;
    import blit_arbiter_pkg::*;

    localparam int BT = 8;
    localparam int DT = 20;
    localparam int CW = 4;

    typedef enum int {EV_GNT, EV_DONE, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int          port;
        int          cyc;
        logic [31:0] cmd;
        int          cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blit_arbiter_if #(.CNT_W(CW)) bus ();

    blit_arbiter #(.BUSY_TIMEOUT(BT), .DONE_TIMEOUT(DT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];

    // reference model state
    int last_srv = 1;
    int cnt_mod = 0;
    int err_exp = 0;

    // blitter model state
    int op_len = 1;
    int low_left = 0;
    bit hold_low = 1'b0;

    // monitor-owned observations
    int gnt_cnt[2] = '{0, 0};
    int en_cnt = 0;
    int en_exp = -1;
    int cmd_cyc = -1;
    int cnt_cyc = -1;
    int cnt_exp = 0;
    logic [31:0] cmd_exp = '0;
    bit err_prev = 1'b0;
    bit mon_en = 1'b0;

    // driver-owned bookkeeping
    int gnt_used[2] = '{0, 0};
    int en_used = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    function automatic logic [31:0] blit_bus();
        return {bus.blit_op, bus.blit_src, bus.blit_srcHeight, bus.blit_destX, bus.blit_destY};
    endfunction

    task automatic observe(input ev_kind_e k, input int p);
        ev_t e;
        if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_event", int'(k) * 10 + p, -1);
            return;
        end
        e = exp_q.pop_front();
        check(e.kind == k && e.port == p, "event_kind_port", int'(k) * 10 + p, int'(e.kind) * 10 + e.port);
        check(e.cyc == cyc, "event_cycle", cyc, e.cyc);
        case (k)
            EV_GNT: begin
                en_exp  = cyc + 1;
                cmd_cyc = cyc + 1;
                cmd_exp = e.cmd;
                check(bus.busy == 1'b1, "busy_at_gnt", bus.busy, 1);
            end
            EV_DONE: begin
                cnt_cyc = cyc + 1;
                cnt_exp = e.cnt;
                check(blit_bus() == cmd_exp, "cmd_hold_at_done", blit_bus(), cmd_exp);
                check(int'(bus.err) == err_exp, "err_at_done", bus.err, err_exp);
            end
            default: check(bus.busy == 1'b0, "busy_after_abort", bus.busy, 0);
        endcase
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.gnt0 && bus.gnt1) check(1'b0, "dual_gnt", 2, 1);
            if (bus.done0) observe(EV_DONE, 0);
            if (bus.done1) observe(EV_DONE, 1);
            if (bus.err && !err_prev) observe(EV_ERR, 0);
            if (bus.gnt0) begin gnt_cnt[0]++; observe(EV_GNT, 0); end
            if (bus.gnt1) begin gnt_cnt[1]++; observe(EV_GNT, 1); end
            if (bus.blit_enable) en_cnt++;
            if (bus.blit_enable || cyc == en_exp)
                check(bus.blit_enable && cyc == en_exp, "enable_pulse", bus.blit_enable, cyc == en_exp);
            if (cyc == cmd_cyc) check(blit_bus() == cmd_exp, "cmd_capture", blit_bus(), cmd_exp);
            if (cyc == cnt_cyc) check(int'(bus.blit_count) == cnt_exp, "blit_count", bus.blit_count, cnt_exp);
        end
        err_prev = bus.err;
    end

    // One cycle of stimulus: retire granted requests, then run the blitter model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gnt_cnt[0] != gnt_used[0]) begin gnt_used[0] = gnt_cnt[0]; bus.req0 = 1'b0; end
        if (gnt_cnt[1] != gnt_used[1]) begin gnt_used[1] = gnt_cnt[1]; bus.req1 = 1'b0; end
        if (en_cnt != en_used) begin en_used = en_cnt; low_left = op_len; end
        bus.blit_ready = !(hold_low || low_left != 0);
        if (low_left > 0) low_left--;
    endtask

    task automatic set_req(input int p, input logic [31:0] c);
        if (p == 0) begin bus.req0 = 1'b1; bus.cmd0 = c; end
        else        begin bus.req1 = 1'b1; bus.cmd1 = c; end
    endtask

    task automatic push(input ev_kind_e k, input int p, input int c, input logic [31:0] cmd, input int cnt);
        ev_t e;
        e.kind = k; e.port = p; e.cyc = c; e.cmd = cmd; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // cycles from grant to done: ready falls at g+2 for len cycles, or never falls
    function automatic int done_delay(input int len);
        return (len > 0) ? 2 + len : 1 + BT;
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
        if (exp_q.size() != 0) begin
            check(1'b0, "drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
    endtask

    // first requests at c0; second joins with it (late=0) or late cycles later;
    // ready held low for block cycles; len<0 means the blitter never finishes.
    task automatic round(input int first, input bit second, input int late, input int len,
                         input int block, input logic [31:0] c0v, input logic [31:0] c1v);
        logic [31:0] cmd [2];
        int c0, w, l, g, d;
        cmd[0] = c0v;
        cmd[1] = c1v;
        op_len = len;
        hold_low = (block > 0);
        tick();
        c0 = cyc;
        set_req(first, cmd[first]);
        if (second && late == 0) set_req(1 - first, cmd[1 - first]);
        w = (second && late == 0) ? 1 - last_srv : first;
        l = 1 - w;
        g = c0 + block;
        if (len < 0) begin
            push(EV_GNT, w, g, cmd[w], 0);
            push(EV_ERR, 0, g + 3 + DT, '0, 0);
            err_exp = 1;
            last_srv = w;
        end else begin
            d = done_delay(len);
            cnt_mod = (cnt_mod + 1) % (1 << CW);
            push(EV_GNT, w, g, cmd[w], 0);
            push(EV_DONE, w, g + d, '0, cnt_mod);
            last_srv = w;
            if (second) begin
                g = g + d + 1;
                cnt_mod = (cnt_mod + 1) % (1 << CW);
                push(EV_GNT, l, g, cmd[l], 0);
                push(EV_DONE, l, g + d, '0, cnt_mod);
                last_srv = l;
            end
        end
        for (int i = 1; i <= block || i <= late; i++) begin
            if (i == block) hold_low = 1'b0;
            tick();
            if (second && i == late) set_req(1 - first, cmd[1 - first]);
        end
        drain();
    endtask

    task automatic check_idle(input string name);
        check(bus.gnt0 == 1'b0,        {name, "_gnt0"},  bus.gnt0, 0);
        check(bus.gnt1 == 1'b0,        {name, "_gnt1"},  bus.gnt1, 0);
        check(bus.done0 == 1'b0,       {name, "_done0"}, bus.done0, 0);
        check(bus.done1 == 1'b0,       {name, "_done1"}, bus.done1, 0);
        check(bus.blit_enable == 1'b0, {name, "_enable"}, bus.blit_enable, 0);
        check(bus.busy == 1'b0,        {name, "_busy"},  bus.busy, 0);
        check(bus.err == 1'b0,         {name, "_err"},   bus.err, 0);
        check(bus.blit_count == '0,    {name, "_count"}, bus.blit_count, 0);
        check(blit_bus() == '0,        {name, "_cmd"},   blit_bus(), 0);
    endtask

    task automatic model_reset();
        last_srv = 1;
        cnt_mod = 0;
        err_exp = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_pulse");
        model_reset();
    endtask

    initial begin
        int g_before;
        logic [31:0] c;
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = '0;
        bus.cmd1 = '0;
        bus.blit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        mon_en = 1'b1;
        model_reset();

        // single CPU sprite op, blitter busy 10 cycles
        round(0, 1'b0, 0, 10, 0, blit_pack(BLIT_OP_SPRITE, 12'h000, 4'd5, 7'd1, 6'd1), $urandom);
        check(int'(bus.blit_count) == 1, "single_count", bus.blit_count, 1);

        // fresh reset, then two simultaneous-request rounds: order 0,1,0,1
        reset_dut();
        round(0, 1'b1, 0, 3, 0, $urandom, $urandom);
        round(1, 1'b1, 0, 2, 0, $urandom, $urandom);

        // zero-length op completes by the busy timeout
        round(1, 1'b0, 0, 0, 0, $urandom, $urandom);
        check(bus.err == 1'b0, "zero_len_err", bus.err, 0);

        // port 1 arrives while port 0 is busy
        round(0, 1'b1, 2, 5, 0, $urandom, $urandom);
        // ready low at IDLE blocks the grant
        round(1, 1'b0, 0, 4, 3, $urandom, $urandom);

        // request withdrawn before it could be granted
        g_before = gnt_cnt[1];
        hold_low = 1'b1;
        tick();
        set_req(1, $urandom);
        repeat (3) tick();
        bus.req1 = 1'b0;
        hold_low = 1'b0;
        repeat (4) tick();
        check(gnt_cnt[1] == g_before, "withdrawn_req", gnt_cnt[1], g_before);

        // blitter hangs: abort sets sticky err, next request still served
        round(0, 1'b0, 0, -1, 0, $urandom, $urandom);
        check(bus.err == 1'b1, "err_set", bus.err, 1);
        low_left = 0;
        round(1, 1'b0, 0, 2, 0, $urandom, $urandom);
        check(bus.err == 1'b1, "err_sticky", bus.err, 1);

        // reset while waiting on the blitter
        op_len = 10;
        tick();
        c = $urandom;
        set_req(0, c);
        push(EV_GNT, 1 - last_srv == 0 ? 0 : 0, cyc, c, 0);
        repeat (5) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_op_reset");
        model_reset();
        repeat (8) tick();

        // counter wrap: 2^CW + 1 completions
        for (int i = 0; i < (1 << CW) + 1; i++) round(0, 1'b0, 0, 1, 0, $urandom, $urandom);
        check(int'(bus.blit_count) == 1, "count_wrap", bus.blit_count, 1);

        // randomized mix
        for (int i = 0; i < 25; i++) begin
            int f, s, lt, ln, bl;
            f  = $urandom_range(0, 1);
            s  = $urandom_range(0, 1);
            lt = s ? $urandom_range(0, 2) : 0;
            ln = $urandom_range(0, 12);
            bl = (lt == 0) ? $urandom_range(0, 2) : 0;
            round(f, s[0], lt, ln, bl, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
